// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters
// (instruction fetch and data) and the downstream memory controller.
// The master view belongs to the arbiter; the slave view belongs to the
// environment, i.e. the requesters and the memory controller together.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  // Data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  // Memory controller
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory controller between an
// instruction-fetch port and a data port. One operation is in flight at a
// time (IDLE -> ISSUE -> DONE). Ties are broken round-robin, a bounded wait
// counter guards against a controller that never acknowledges, and a sticky
// flag records any such timeout until the next reset.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.master bus,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Last ISSUE cycle in which an ack is still accepted; with MAX_WAIT = N the
  // request is presented to the controller for exactly N cycles.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t            state_reg,      state_next;
  logic              grant_reg,      grant_next;
  logic              last_grant_reg, last_grant_next;
  logic [15:0]       wait_cnt_reg,   wait_cnt_next;
  logic              m_we_reg,       m_we_next;
  logic [ADDR_W-1:0] m_addr_reg,     m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg,    m_wdata_next;
  logic [DATA_W-1:0] i_rdata_reg,    i_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg,    d_rdata_next;
  logic              i_ack_reg,      i_ack_next;
  logic              d_ack_reg,      d_ack_next;
  logic              timeout_reg,    timeout_next;

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      grant_reg      <= GRANT_I;
      last_grant_reg <= GRANT_D;   // instruction side wins the first tie
      wait_cnt_reg   <= '0;
      m_we_reg       <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      i_rdata_reg    <= '0;
      d_rdata_reg    <= '0;
      i_ack_reg      <= 1'b0;
      d_ack_reg      <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      wait_cnt_reg   <= wait_cnt_next;
      m_we_reg       <= m_we_next;
      m_addr_reg     <= m_addr_next;
      m_wdata_reg    <= m_wdata_next;
      i_rdata_reg    <= i_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      i_ack_reg      <= i_ack_next;
      d_ack_reg      <= d_ack_next;
      timeout_reg    <= timeout_next;
    end
  end

  // Next-state logic: arbitration in IDLE, wait/timeout in ISSUE, ack in DONE.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    wait_cnt_next   = wait_cnt_reg;
    m_we_next       = m_we_reg;
    m_addr_next     = m_addr_reg;
    m_wdata_next    = m_wdata_reg;
    i_rdata_next    = i_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    i_ack_next      = 1'b0;
    d_ack_next      = 1'b0;
    timeout_next    = timeout_reg;

    case (state_reg)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // Instruction wins when alone or when data was served last.
          if (bus.i_req && (!bus.d_req || (last_grant_reg == GRANT_D))) begin
            grant_next      = GRANT_I;
            last_grant_next = GRANT_I;
            m_we_next       = 1'b0;
            m_addr_next     = bus.i_addr;
            m_wdata_next    = '0;
          end else begin
            grant_next      = GRANT_D;
            last_grant_next = GRANT_D;
            m_we_next       = bus.d_we;
            m_addr_next     = bus.d_addr;
            m_wdata_next    = bus.d_wdata;
          end
          wait_cnt_next = '0;
          state_next    = ISSUE;
        end
      end

      ISSUE: begin
        wait_cnt_next = wait_cnt_reg + 16'd1;
        if (bus.m_ack) begin
          state_next = DONE;
          if (grant_reg == GRANT_I) begin
            i_rdata_next = bus.m_rdata;
            i_ack_next   = 1'b1;
          end else begin
            // A write leaves the data port's read value untouched.
            if (!m_we_reg) begin
              d_rdata_next = bus.m_rdata;
            end
            d_ack_next = 1'b1;
          end
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Controller never answered: complete with zero data and flag it.
          state_next   = DONE;
          timeout_next = 1'b1;
          if (grant_reg == GRANT_I) begin
            i_rdata_next = '0;
            i_ack_next   = 1'b1;
          end else begin
            if (!m_we_reg) begin
              d_rdata_next = '0;
            end
            d_ack_next = 1'b1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.m_req   = (state_reg == ISSUE);
  assign bus.m_we    = m_we_reg;
  assign bus.m_addr  = m_addr_reg;
  assign bus.m_wdata = m_wdata_reg;
  assign bus.i_rdata = i_rdata_reg;
  assign bus.i_ack   = i_ack_reg;
  assign bus.d_rdata = d_rdata_reg;
  assign bus.d_ack   = d_ack_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory issues
// and expected acks into queues, a monitor pops and compares them as the
// DUT presents m_req rising edges and i_ack/d_ack pulses.
module tb_mem_arbiter;

  logic clock;
  logic reset_n;
  logic busy;
  logic timeout_err;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int compared   = 0;
  int mismatched = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        port;   // 0 = instruction, 1 = data
    logic [31:0] rdata;
  } ack_exp_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  // Memory controller model
  logic [31:0] mem_tbl [logic [31:0]];
  int          ack_delay;     // extra ISSUE cycles before ack; -1 = never
  logic        ack_model;
  logic        ack_inject;
  logic [31:0] rdata_model;

  assign bus.m_ack   = ack_model | ack_inject;
  assign bus.m_rdata = rdata_model;

  initial begin
    int cnt;
    cnt         = 0;
    ack_model   = 1'b0;
    rdata_model = 32'hDEADBEEF;
    forever begin
      @(negedge clock);
      ack_model   = 1'b0;
      rdata_model = 32'hDEADBEEF;
      if (bus.m_req && reset_n) begin
        cnt++;
        if (ack_delay >= 0 && cnt == ack_delay + 1) begin
          ack_model = 1'b1;
          if (mem_tbl.exists(bus.m_addr)) rdata_model = mem_tbl[bus.m_addr];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor / scoreboard
  int          last_req_len = 0;
  initial begin
    logic        prev_m_req;
    logic        prev_mack;
    logic        prev_ack;
    int          run_len;
    logic        held_we;
    logic [31:0] held_addr;
    logic [31:0] held_wdata;
    mem_exp_t    me;
    ack_exp_t    ae;
    prev_m_req = 1'b0;
    prev_mack  = 1'b0;
    prev_ack   = 1'b0;
    run_len    = 0;
    held_we    = 1'b0;
    held_addr  = '0;
    held_wdata = '0;
    forever begin
      @(negedge clock);
      if (bus.m_req === 1'b1 && !prev_m_req) begin
        check("issue_expected", mem_q.size() != 0, 1);
        if (mem_q.size() != 0) begin
          me = mem_q.pop_front();
          check("m_we", bus.m_we, me.we);
          check("m_addr", bus.m_addr, me.addr);
          check("m_wdata", bus.m_wdata, me.wdata);
          $display("issue we=%0d addr=0x%08h wdata=0x%08h", bus.m_we, bus.m_addr, bus.m_wdata);
        end
        held_we    = bus.m_we;
        held_addr  = bus.m_addr;
        held_wdata = bus.m_wdata;
      end else if (bus.m_req === 1'b1) begin
        check("m_we_stable", bus.m_we, held_we);
        check("m_addr_stable", bus.m_addr, held_addr);
        check("m_wdata_stable", bus.m_wdata, held_wdata);
      end

      if (bus.m_req === 1'b1) begin
        run_len++;
      end else if (prev_m_req) begin
        last_req_len = run_len;
        run_len      = 0;
      end

      if (prev_mack) check("ack_latency", bus.i_ack | bus.d_ack, 1);
      if (prev_ack)  check("idle_after_ack", busy, 0);

      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        check("single_ack", bus.i_ack & bus.d_ack, 0);
        check("ack_expected", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) begin
          ae = ack_q.pop_front();
          check("ack_port", bus.d_ack, ae.port);
          if (ae.port) check("d_rdata", bus.d_rdata, ae.rdata);
          else         check("i_rdata", bus.i_rdata, ae.rdata);
        end
        $display("ack port=%s rdata=0x%08h", bus.d_ack ? "D" : "I",
                 bus.d_ack ? bus.d_rdata : bus.i_rdata);
      end

      prev_m_req = (bus.m_req === 1'b1);
      prev_mack  = (bus.m_req === 1'b1) && (bus.m_ack === 1'b1);
      prev_ack   = (bus.i_ack === 1'b1) || (bus.d_ack === 1'b1);
    end
  end

  // Requester drivers: raise at a negedge, hold until ack, drop right after.
  task automatic run_i(input logic [31:0] addr);
    bit got = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (bus.i_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("i_ack_seen", got, 1);
    bus.i_req = 1'b0;
  endtask

  task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 0;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    for (int c = 0; c < 64; c++) begin
      @(negedge clock);
      if (bus.d_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("d_ack_seen", got, 1);
    bus.d_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [31:0] i_tbl [4];
    logic [31:0] d_tbl [4];
    bit          got;
    i_tbl = '{32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003};
    d_tbl = '{32'h22220000, 32'h22220001, 32'h22220002, 32'h22220003};

    reset_n     = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    ack_inject  = 1'b0;
    ack_delay   = 1;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_m_req", bus.m_req, 0);
    check("rst_m_we", bus.m_we, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_i_ack", bus.i_ack, 0);
    check("rst_d_ack", bus.d_ack, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_timeout", timeout_err, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Stray m_ack while idle is ignored
    ack_inject = 1'b1;
    @(negedge clock);
    ack_inject = 1'b0;
    check("stray_ack_busy", busy, 0);
    check("stray_ack_i_ack", bus.i_ack, 0);
    check("stray_ack_d_ack", bus.d_ack, 0);
    @(negedge clock);
    check("stray_ack_busy2", busy, 0);
    check("stray_ack_acks2", bus.i_ack | bus.d_ack, 0);

    // Round-robin ties from reset: I, D, I, D ...
    do_reset();
    ack_delay = 1;
    for (int k = 0; k < 4; k++) begin
      mem_tbl[32'h1000 + 32'(k * 4)] = i_tbl[k];
      mem_tbl[32'h8000 + 32'(k * 4)] = d_tbl[k];
      mem_q.push_back('{1'b0, 32'h1000 + 32'(k * 4), 32'h0});
      mem_q.push_back('{1'b0, 32'h8000 + 32'(k * 4), 32'hFFFF0000 + 32'(k)});
      ack_q.push_back('{1'b0, i_tbl[k]});
      ack_q.push_back('{1'b1, d_tbl[k]});
      fork
        run_i(32'h1000 + 32'(k * 4));
        run_d(1'b0, 32'h8000 + 32'(k * 4), 32'hFFFF0000 + 32'(k));
      join
    end

    // Instruction read, ack three cycles after m_req (last allowed cycle)
    @(negedge clock);
    ack_delay = 3;
    mem_tbl[32'h100] = 32'h2402000A;
    mem_q.push_back('{1'b0, 32'h100, 32'h0});
    ack_q.push_back('{1'b0, 32'h2402000A});
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    @(negedge clock);
    check("m_req_latency", bus.m_req, 1);
    got = 0;
    for (int c = 0; c < 64; c++) begin
      if (bus.i_ack === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    check("i_ack_seen_0x100", got, 1);
    bus.i_req = 1'b0;
    check("no_timeout_at_boundary", timeout_err, 0);

    // Data read, ack in the first ISSUE cycle
    ack_delay = 0;
    mem_tbl[32'h3000] = 32'h13572468;
    mem_q.push_back('{1'b0, 32'h3000, 32'h0});
    ack_q.push_back('{1'b1, 32'h13572468});
    run_d(1'b0, 32'h3000, 32'h0);

    // Data write: d_rdata keeps the previous read value
    ack_delay = 2;
    mem_q.push_back('{1'b1, 32'h2000, 32'hCAFEF00D});
    ack_q.push_back('{1'b1, 32'h13572468});
    run_d(1'b1, 32'h2000, 32'hCAFEF00D);

    // Timeout: controller silent, MAX_WAIT = 4
    ack_delay = -1;
    mem_q.push_back('{1'b0, 32'h4000, 32'h0});
    ack_q.push_back('{1'b1, 32'h0});
    run_d(1'b0, 32'h4000, 32'h0);
    @(negedge clock);
    check("timeout_req_len", last_req_len, 4);
    check("timeout_err_set", timeout_err, 1);

    // Sticky flag survives later normal traffic
    ack_delay = 1;
    mem_tbl[32'h200] = 32'h0000BEEF;
    mem_q.push_back('{1'b0, 32'h200, 32'h0});
    ack_q.push_back('{1'b0, 32'h0000BEEF});
    run_i(32'h200);
    @(negedge clock);
    check("timeout_err_sticky", timeout_err, 1);

    // Reset during ISSUE aborts without an ack
    ack_delay = -1;
    mem_q.push_back('{1'b0, 32'h5000, 32'h0});
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h5000;
    repeat (2) @(negedge clock);
    check("pre_reset_m_req", bus.m_req, 1);
    reset_n   = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clock);
    check("abort_m_req", bus.m_req, 0);
    check("abort_busy", busy, 0);
    check("abort_timeout", timeout_err, 0);
    check("abort_acks", bus.i_ack | bus.d_ack, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_acks2", bus.i_ack | bus.d_ack, 0);

    // Normal request after the aborted one
    ack_delay = 1;
    mem_tbl[32'h6000] = 32'h600DCAFE;
    mem_q.push_back('{1'b0, 32'h6000, 32'h0});
    ack_q.push_back('{1'b1, 32'h600DCAFE});
    run_d(1'b0, 32'h6000, 32'h0);

    repeat (4) @(negedge clock);
    check("mem_q_drained", mem_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
